// File: rtl/fp_add_pkg.sv
// Shared binary32 field widths, constants, FSM state type and operand unpacking
// for the sequential FP adder.
package fp_add_pkg;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MAN_W    = 23;
  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, PACK} state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   mant;
  } operand_t;

  // exp=0 inputs (zero and denormals) become signed zero; others get the hidden 1
  function automatic operand_t unpack(input logic [31:0] x);
    operand_t o;
    o.sign = x[31];
    o.exp  = x[30:23];
    o.mant = (x[30:23] == '0) ? '0 : {1'b1, x[22:0]};
    if (x[30:23] == '0) o.exp = '0;
    return o;
  endfunction
endpackage

// File: rtl/fp_norm_encoder.sv
// Leading-one priority encoder: bit 23 -> 24 ... bit 0 -> 1, no bit set -> 0.
module fp_norm_encoder (
  input  logic [23:0] m,
  output logic [4:0]  pos
);
  always_comb begin
    pos = '0;
    for (int unsigned i = 0; i < 24; i++) begin
      if (m[i]) pos = 5'(i + 1);
    end
  end
endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle binary32 adder: IDLE -> ALIGN -> ADD -> NORM -> PACK.
// Define FP_ADD_SEQ_ROUND_EN for round-to-nearest-even; otherwise results truncate.
module fp_add_seq
  import fp_add_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow
);
  state_t state;
  logic [31:0] ra, rb;

  logic        al_sign, al_sub, al_spec;
  logic [31:0] al_spec_res;
  logic [7:0]  al_exp;
  logic [26:0] al_big, al_small;

  logic        ad_sign, ad_spec;
  logic [31:0] ad_spec_res;
  logic [7:0]  ad_exp;
  logic [27:0] ad_sum;

  logic              nm_sign, nm_zero, nm_spec;
  logic [31:0]       nm_spec_res;
  logic signed [9:0] nm_exp;
  logic [26:0]       nm_m;

  // ALIGN: unpack, order by magnitude, shift smaller keeping guard/round/sticky
  operand_t    ua, ub, big, sml;
  logic [7:0]  diff;
  logic [26:0] ext, mask, sm_sh;
  logic        a_nan, b_nan, a_inf, b_inf, c_spec;
  logic [31:0] c_spec_res;

  always_comb begin
    ua = unpack(ra);
    ub = unpack(rb);
    if ({ub.exp, ub.mant} > {ua.exp, ua.mant}) begin
      big = ub; sml = ua;
    end else begin
      big = ua; sml = ub;
    end
    diff = big.exp - sml.exp;
    ext  = {sml.mant, 3'b000};
    mask = '1;
    mask = ~(mask << diff);
    if (diff >= 8'd26) sm_sh = {26'b0, |sml.mant};
    else               sm_sh = (ext >> diff) | {26'b0, |(ext & mask)};

    a_nan  = (ra[30:23] == 8'hFF) && (ra[22:0] != '0);
    b_nan  = (rb[30:23] == 8'hFF) && (rb[22:0] != '0);
    a_inf  = (ra[30:23] == 8'hFF) && (ra[22:0] == '0);
    b_inf  = (rb[30:23] == 8'hFF) && (rb[22:0] == '0);
    c_spec = a_nan | b_nan | a_inf | b_inf;
    if (a_nan || b_nan || (a_inf && b_inf && (ra[31] != rb[31]))) c_spec_res = QNAN;
    else if (a_inf)                                                 c_spec_res = ra;
    else                                                            c_spec_res = rb;
  end

  logic [27:0] c_sum;
  always_comb begin
    if (al_sub) c_sum = {1'b0, al_big} - {1'b0, al_small};
    else        c_sum = {1'b0, al_big} + {1'b0, al_small};
  end

  logic [4:0]        enc_pos, sh;
  logic [26:0]       n_m;
  logic signed [9:0] n_exp;
  logic              n_zero, n_sign;

  fp_norm_encoder u_enc (
    .m   (ad_sum[26:3]),
    .pos (enc_pos)
  );

  always_comb begin
    sh     = 5'd24 - enc_pos;
    n_m    = '0;
    n_exp  = $signed({2'b00, ad_exp});
    n_zero = 1'b0;
    n_sign = ad_sign;
    if (ad_sum[27]) begin
      n_m   = {ad_sum[27:2], ad_sum[1] | ad_sum[0]};
      n_exp = $signed({2'b00, ad_exp}) + 10'sd1;
    end else if (enc_pos == '0) begin
      n_zero = 1'b1;
      n_sign = 1'b0;
    end else begin
      n_m   = ad_sum[26:0] << sh;
      n_exp = $signed({2'b00, ad_exp}) - $signed({5'b0, sh});
      if (n_exp <= 10'sd0) n_zero = 1'b1;
    end
  end

  // PACK: optional round-to-nearest-even; a rounding carry-out leaves a zero field
  logic [22:0]       p_field;
  logic signed [9:0] p_exp;
  logic [31:0]       p_res;
  logic              p_ovf;

  always_comb begin
`ifdef FP_ADD_SEQ_ROUND_EN
    logic        rnd_up;
    logic [24:0] m_rnd;
    rnd_up  = nm_m[2] & (nm_m[1] | nm_m[0] | nm_m[3]);
    m_rnd   = {1'b0, nm_m[26:3]} + {24'b0, rnd_up};
    p_field = m_rnd[22:0];
    p_exp   = nm_exp + $signed({9'b0, m_rnd[24]});
`else
    p_field = nm_m[25:3];
    p_exp   = nm_exp;
`endif
    p_ovf = 1'b0;
    if (nm_spec)                    p_res = nm_spec_res;
    else if (nm_zero)               p_res = {nm_sign, 31'b0};
    else if (p_exp >= 10'sd255) begin
      p_res = {nm_sign, 8'hFF, 23'b0};
      p_ovf = 1'b1;
    end else                        p_res = {nm_sign, p_exp[7:0], p_field};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0; done <= 1'b0; result <= '0; overflow <= 1'b0;
      ra <= '0; rb <= '0;
      al_sign <= 1'b0; al_sub <= 1'b0; al_spec <= 1'b0; al_spec_res <= '0;
      al_exp <= '0; al_big <= '0; al_small <= '0;
      ad_sign <= 1'b0; ad_spec <= 1'b0; ad_spec_res <= '0; ad_exp <= '0; ad_sum <= '0;
      nm_sign <= 1'b0; nm_zero <= 1'b0; nm_spec <= 1'b0; nm_spec_res <= '0;
      nm_exp <= '0; nm_m <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ra    <= a;
          rb    <= b;
          busy  <= 1'b1;
          state <= ALIGN;
        end
        ALIGN: begin
          al_sign     <= big.sign;
          al_sub      <= ua.sign ^ ub.sign;
          al_spec     <= c_spec;
          al_spec_res <= c_spec_res;
          al_exp      <= big.exp;
          al_big      <= {big.mant, 3'b000};
          al_small    <= sm_sh;
          state       <= ADD;
        end
        ADD: begin
          ad_sign     <= al_sign;
          ad_spec     <= al_spec;
          ad_spec_res <= al_spec_res;
          ad_exp      <= al_exp;
          ad_sum      <= c_sum;
          state       <= NORM;
        end
        NORM: begin
          nm_sign     <= n_sign;
          nm_zero     <= n_zero;
          nm_spec     <= ad_spec;
          nm_spec_res <= ad_spec_res;
          nm_exp      <= n_exp;
          nm_m        <= n_m;
          state       <= PACK;
        end
        PACK: begin
          result   <= p_res;
          overflow <= p_ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_seq.sv
// Self-checking bench for fp_add_seq: directed corners, randomized operands against
// an integer reference model, back-to-back starts and reset mid-operation.
module tb_fp_add_seq;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b;
  logic        busy, done, overflow;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_add_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .overflow(overflow)
  );

  // Reference: returns {overflow, result}
  function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, eb, es, d, e;
    longint mx, my, mb, ms, bigv, sm, s, mant;
    logic sx, sy, sb, ss, xnan, ynan, xinf, yinf;
    logic [31:0] r;
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    sx = x[31]; sy = y[31];
    xnan = (ex == 255) && (x[22:0] != 0); ynan = (ey == 255) && (y[22:0] != 0);
    xinf = (ex == 255) && (x[22:0] == 0); yinf = (ey == 255) && (y[22:0] == 0);
    if (xnan || ynan || (xinf && yinf && sx != sy)) return {1'b0, 32'h7FC0_0000};
    if (xinf) return {1'b0, x};
    if (yinf) return {1'b0, y};
    mx = (ex == 0) ? 0 : (longint'(x[22:0]) + (longint'(1) << 23));
    my = (ey == 0) ? 0 : (longint'(y[22:0]) + (longint'(1) << 23));
    if (ex == 0) ex = 0;
    if (ey == 0) ey = 0;
    if ((longint'(ey) << 24) + my > (longint'(ex) << 24) + mx) begin
      eb = ey; mb = my; sb = sy; es = ex; ms = mx; ss = sx;
    end else begin
      eb = ex; mb = mx; sb = sx; es = ey; ms = my; ss = sy;
    end
    d = eb - es;
    bigv = mb * 8;
    if (d >= 26) sm = (ms != 0) ? 1 : 0;
    else begin
      sm = (ms * 8) >> d;
      if (((ms * 8) % (longint'(1) << d)) != 0) sm = sm | 1;
    end
    s = (sb == ss) ? bigv + sm : bigv - sm;
    e = eb;
    if (s >= (longint'(1) << 27)) begin
      s = (s >> 1) | (s & 1);
      e = e + 1;
    end else if ((s >> 3) == 0) begin
      return {1'b0, 32'h0};
    end else begin
      while (s < (longint'(1) << 26)) begin s = s * 2; e = e - 1; end
      if (e <= 0) return {1'b0, sb, 31'b0};
    end
    mant = s >> 3;
`ifdef FP_ADD_SEQ_ROUND_EN
    if ((s % 8) > 4 || ((s % 8) == 4 && (mant % 2) == 1)) mant = mant + 1;
    if (mant == (longint'(1) << 24)) begin mant = mant >> 1; e = e + 1; end
`endif
    if (e >= 255) return {1'b1, sb, 8'hFF, 23'h0};
    r = {sb, e[7:0], mant[22:0]};
    return {1'b0, r};
  endfunction

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, output int lat,
                        output logic [31:0] r, output logic ov, output logic busy_acc,
                        output logic busy_after, output logic done_after);
    @(negedge clk); a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    busy_acc = busy;
    lat = 0;
    while (done !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
    r = result; ov = overflow; busy_after = busy;
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 32'h3F80_0000; b = 32'h3F80_0000;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 0", result); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow); end
    @(negedge clk); start = 1'b0; rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] ta [8] = '{32'h3F80_0000, 32'h4040_0000, 32'h3F80_0000, 32'h7F7F_FFFF,
                            32'h7F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC1_2345};
    logic [31:0] tb [8] = '{32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000, 32'h7F7F_FFFF,
                            32'hFF80_0000, 32'h33C0_0000, 32'h0040_0000, 32'h3F80_0000};
    logic [31:0] tr [8];
    logic        tov [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int lat; logic [31:0] r; logic ov, bacc, baft, daft;
    tr = '{32'h4000_0000, 32'h4000_0000, 32'h0000_0000, 32'h7F80_0000,
           32'h7FC0_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000};
`ifdef FP_ADD_SEQ_ROUND_EN
    tr[5] = 32'h3F80_0001;
`endif
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb[i], lat, r, ov, bacc, baft, daft);
      n_cmp++; if (r !== tr[i]) begin n_err++; $display("FAIL dir%0d_result %h+%h got %h want %h", i, ta[i], tb[i], r, tr[i]); end
      n_cmp++; if (ov !== tov[i]) begin n_err++; $display("FAIL dir%0d_ovf got %b want %b", i, ov, tov[i]); end
      n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL dir%0d_latency got %0d want 4", i, lat); end
      n_cmp++; if (bacc !== 1'b1) begin n_err++; $display("FAIL dir%0d_busy_accept got %b want 1", i, bacc); end
      n_cmp++; if (baft !== 1'b0) begin n_err++; $display("FAIL dir%0d_busy_done got %b want 0", i, baft); end
      n_cmp++; if (daft !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_width got %b want 0", i, daft); end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] r, x, y; logic ov, bacc, baft, daft; logic [32:0] exp_v;
    for (int i = 0; i < 300; i++) begin
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = $urandom;
        1: y = {1'($urandom), 8'(x[30:23] + 8'($urandom_range(0, 6)) - 8'd3), 23'($urandom)};
        2: y = x ^ 32'h8000_0000;
        default: y = {~x[31], 8'(x[30:23] - 8'($urandom_range(0, 1))), 23'($urandom)};
      endcase
      run_op(x, y, lat, r, ov, bacc, baft, daft);
      exp_v = ref_add(x, y);
      n_cmp++; if (r !== exp_v[31:0]) begin n_err++; $display("FAIL rnd_result %h+%h got %h want %h", x, y, r, exp_v[31:0]); end
      n_cmp++; if (ov !== exp_v[32]) begin n_err++; $display("FAIL rnd_ovf %h+%h got %b want %b", x, y, ov, exp_v[32]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] oa [12], ob [12];
    logic [31:0] got [$];
    logic [32:0] exp_v;
    int idx;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i < 12) begin
        oa[i] = $urandom; ob[i] = $urandom;
        a = oa[i]; b = ob[i]; start = 1'b1;
      end else begin
        start = 1'b0; a = $urandom; b = $urandom;
      end
      @(posedge clk); #1;
      if (done === 1'b1) got.push_back(result);
    end
    n_cmp++; if (got.size() !== 3) begin n_err++; $display("FAIL b2b_count got %0d want 3", got.size()); end
    for (int k = 0; k < 3; k++) begin
      idx = 5 * k;
      exp_v = ref_add(oa[idx], ob[idx]);
      if (k < got.size()) begin
        n_cmp++; if (got[k] !== exp_v[31:0]) begin n_err++; $display("FAIL b2b_result%0d got %h want %h", k, got[k], exp_v[31:0]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, ndone; logic [31:0] r; logic ov, bacc, baft, daft;
    run_op(32'h3F80_0000, 32'h3F80_0000, lat, r, ov, bacc, baft, daft);
    @(negedge clk); a = 32'h7F7F_FFFF; b = 32'h7F7F_FFFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_done got %b want 0", done); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL mid_result got %h want 0", result); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_ovf got %b want 0", overflow); end
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (done === 1'b1) ndone++; end
    n_cmp++; if (ndone !== 0) begin n_err++; $display("FAIL mid_no_done got %0d want 0", ndone); end
    run_op(32'h4040_0000, 32'hBF80_0000, lat, r, ov, bacc, baft, daft);
    n_cmp++; if (r !== 32'h4000_0000) begin n_err++; $display("FAIL mid_after_result got %h want 40000000", r); end
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL mid_after_latency got %0d want 4", lat); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fp_add_seq.md
# fp_add_seq

Multi-cycle IEEE-754 binary32 adder controller for the belief-propagation message datapath. It accepts one operand pair per start pulse and sequences it through unpack/align, add/subtract, normalize and pack states. Normalization uses a leading-one priority encoder. The block returns one result with a single-cycle done pulse and is the shared FP add resource for check- and variable-node updates.

## Interface
- Parameters: none; format fixed at binary32, field widths come from the package.
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- a  in  32  operand A, sampled on the accept edge
- b  in  32  operand B, sampled on the accept edge
- busy  out  1  high from the accept edge until the result edge
- done  out  1  one-cycle pulse; result valid
- result  out  32  sum; held until the next done
- overflow  out  1  set with done when a finite sum rounds to ±inf; held with result

## Operation
- **FSM states:** IDLE → ALIGN → ADD → NORM → PACK → IDLE, one state per cycle, with no stalls.
- **IDLE:**
  - If start=1, register a and b, set busy=1 and go to ALIGN.
  - start while busy is ignored and not queued.
- **ALIGN:**
  - Inputs with exp=0 are flushed to signed zero.
  - Prepend the hidden 1.
  - Order the operands by (exp, mantissa) magnitude.
  - Shift the smaller mantissa right by the exponent difference.
  - Keep guard/round/sticky bits.
  - A difference ≥26 makes the smaller operand sticky-only.
- **ADD:**
  - Equal signs: add.
  - Opposite signs: larger minus smaller.
  - 25-bit magnitude (carry + 24 bits); sign = sign of the larger operand.
- **NORM:**
  - Carry set: shift right 1 and increment exp.
  - Otherwise the priority encoder gives the leading-one position p (1..24, 0 = all zero).
  - Shift left by 24−p and subtract the same amount from exp.
  - p=0 gives +0.
  - An exponent that falls to ≤0 flushes to signed zero.
- **PACK:**
  - Apply rounding.
  - exp ≥255 gives ±inf (0x7F800000 | sign) with overflow=1.
  - Register result, overflow and done.
- **Specials (always handled):**
  - Any NaN input, or +inf + −inf, gives 0x7FC00000.
  - inf + finite gives that inf, with overflow=0.
- **Exact cancellation:** x + (−x) = 0x00000000 (+0).

## Timing
- **Reset values:** state=IDLE, busy=0, done=0, result=0x00000000, overflow=0.
- **Latency:**
  - Accept edge E0; the result, overflow and done register on E4.
  - done is high for exactly the one cycle after E4.
  - busy is high E0..E4 and low after E4.
- **Back-to-back:** start may be high during the done cycle and is accepted at E5. Throughput is one operation per 5 cycles.
- **Operand stability:** a and b need only be valid in the accept cycle.
- **Reset mid-operation:** immediately return to the reset values. No done is produced for the aborted operation.
- **Output hold:** result and overflow are stable between done pulses.

## Configuration
- **FP_ADD_SEQ_ROUND_EN defined:** round-to-nearest-even in PACK using guard/round/sticky. A mantissa carry-out on rounding increments exp, which may cause overflow.
- **FP_ADD_SEQ_ROUND_EN undefined:** truncate (round toward zero). Guard/round/sticky logic is removed.
- Latency is identical in both builds.

## Structure
- **Package fp_add_pkg:**
  - EXP_W=8, MAN_W=23, EXP_BIAS=127, EXP_MAX=255.
  - QNAN=32'h7FC00000.
  - State enum {IDLE, ALIGN, ADD, NORM, PACK}.
  - Unpacked-operand struct {sign, exp, mant[23:0]}.
- **Sub-module fp_norm_encoder:**
  - Combinational 24-bit leading-one priority encoder, 5-bit output.
  - Encoding: bit 23 → 24 … bit 0 → 1, none → 0.
  - Instantiated once in NORM.

## Test plan
- 0x3F800000 + 0x3F800000 → result 0x40000000, overflow=0, done exactly 1 cycle, 4 edges after the accept edge; busy low afterwards.
- 0x40400000 + 0xBF800000 → 0x40000000 (left-normalize path); 0x3F800000 + 0xBF800000 → 0x00000000.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1; 0x7F800000 + 0xFF800000 → 0x7FC00000, overflow=0.
- 0x3F800000 + 0x33C00000 → 0x3F800000 without the macro, 0x3F800001 with FP_ADD_SEQ_ROUND_EN; 0x3F800000 + 0x00400000 (denormal) → 0x3F800000.
- start held high for 12 cycles with changing operands → exactly 3 results.
  - Results use the operands sampled at E0, E5 and E10.
  - Operands presented while busy are ignored.
- Assert rst during NORM → busy/done/result/overflow read 0 in the following cycle, no done pulse appears; a new start after release completes normally.
